ibex_fetch_fifo: RTL and testbench
==================================

IBEX_FETCH_FIFO -- requirements
Module: ibex_fetch_fifo

Interface
REQ-001 SHALL have parameter FifoDepth, default 3: word entries in the instruction queue, legal range 2..8.
REQ-002 SHALL have parameter MaxOutstanding, default 2: ungranted-plus-granted requests awaiting rvalid, legal range 1..2.
REQ-003 SHALL use one clock and an asynchronous active-low reset; all state is reset asynchronously on rst_ni low.
REQ-004 SHALL have port clk_i  in  1  clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous reset, active low.
REQ-006 SHALL have port req_i  in  1  fetch enable; low blocks new memory requests.
REQ-007 SHALL have port branch_i  in  1  redirect fetch to addr_i and flush.
REQ-008 SHALL have port addr_i  in  32  branch target, halfword aligned; addr_i[0] ignored.
REQ-009 SHALL have port ready_i  in  1  consumer accepts rdata_o this cycle.
REQ-010 SHALL have port valid_o  out  1  rdata_o/addr_o hold a complete instruction.
REQ-011 SHALL have port rdata_o  out  32  instruction bits, low halfword at addr_o.
REQ-012 SHALL have port addr_o  out  32  PC of rdata_o.
REQ-013 SHALL have ports instr_req_o out 1, instr_addr_o out 32, instr_gnt_i in 1, instr_rvalid_i in 1, instr_rdata_i in 32: memory request/grant/response bus.
REQ-014 SHALL have port busy_o  out  1  request pending or any response outstanding.

Function
REQ-015 Word pointer fetch_addr_q: branch_i loads {addr_i[31:2],2'b00}; each grant (instr_req_o & instr_gnt_i) adds 4, wrapping modulo 2^32.
REQ-016 instr_addr_o SHALL equal the request's address, word aligned, and be stable from assertion of instr_req_o until grant.
REQ-017 A new request SHALL start only when req_i=1, no branch_i this cycle, outstanding < MaxOutstanding, and fifo_count + outstanding < FifoDepth.
REQ-018 Once asserted, instr_req_o SHALL stay high until granted, even if req_i drops or branch_i occurs; a request pending at branch is marked for discard.
REQ-019 First request after branch_i SHALL appear no earlier than the next cycle, at the new word address.
REQ-020 Responses return in order; a non-discarded rvalid pushes instr_rdata_i into the queue (visible next cycle, no bypass); a discarded one decrements discard count only.
REQ-021 On branch_i: queue emptied, addr_o <= {addr_i[31:1],1'b0}, discard count <= outstanding after this cycle's grant/rvalid updates; a same-cycle rvalid is also dropped.
REQ-022 Aligned (addr_o[1]=0): valid_o when count>=1; rdata_o = entry0.
REQ-023 Unaligned: rdata_o[15:0] = entry0[31:16]; if entry0[17:16]!=2'b11, valid_o with count>=1 (rdata_o[31:16] = entry1[15:0] or 0 if absent); else valid_o needs count>=2, rdata_o[31:16] = entry1[15:0].
REQ-024 Accept (valid_o & ready_i): length = 2 if rdata_o[1:0]!=2'b11 else 4; addr_o += length.
REQ-025 Pop entry0 on accept except aligned compressed (no pop, addr_o[1] becomes 1).
REQ-026 valid_o SHALL be 0 in any cycle with branch_i=1; branch_i overrides same-cycle accept.
REQ-027 Push and pop in the same cycle SHALL keep count unchanged; push never occurs when full (guaranteed by REQ-017).
REQ-028 busy_o = instr_req_o | (outstanding != 0).
REQ-029 rvalid with outstanding=0, or grant without request, is illegal; behaviour undefined, flagged by assertion.

Reset
REQ-030 On reset: instr_req_o=0, valid_o=0, busy_o=0, rdata_o=0 (queue cleared), addr_o=0, instr_addr_o=0, outstanding=0, discard=0, count=0.
REQ-031 Reset asserted mid-transaction SHALL drop all outstanding state; post-reset rvalids before any request are illegal stimulus.

Verification
REQ-032 Branch to 0x100, gnt same cycle, rvalid next with 0x00000013 -> requests at 0x100, 0x104; valid_o with rdata_o=0x00000013, addr_o=0x100.
REQ-033 Branch to 0x102, word 0x4501_0001 (upper 0x4501 compressed) -> rdata_o[15:0]=0x4501, addr_o=0x102, one pop, addr_o then 0x104.
REQ-034 Branch to 0x202, words 0x0093_0000 then 0x0000_0513 -> valid_o only after second word, rdata_o=0x0513_0093, addr_o=0x202; next addr_o=0x206.
REQ-035 Two outstanding at 0x300/0x304, branch to 0x400 -> both rvalids discarded, no push, next request at 0x400, valid_o stays 0 until its data.
REQ-036 req_i=1, ready_i=0, responses every cycle, depth 3 -> at most 3 words held, instr_req_o blocked while count+outstanding=3; one accept re-enables requesting.
REQ-037 Branch with instr_req_o high and gnt withheld 3 cycles -> instr_addr_o unchanged; granted request discarded; new target requested next cycle.

Source files
------------

// File: rtl/ibex_fetch_fifo.sv
// Instruction prefetch queue: issues word fetches on the memory bus, realigns
// compressed and uncompressed instructions and flushes on branches.
module ibex_fetch_fifo #(
   parameter int unsigned FifoDepth      = 3,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] addr_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   output logic        busy_o
);

   localparam int unsigned CntW  = $clog2(FifoDepth + 1);
   localparam int unsigned FillW = CntW + 1;
   localparam int unsigned OutW  = 2;

   logic [31:0]     fetch_addr_q, fetch_addr_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic [31:0]     pc_q, pc_d;
   logic            req_pend_q, req_pend_d;
   logic            req_stale_q, req_stale_d;
   logic [OutW-1:0] out_q, out_d;
   logic [OutW-1:0] discard_q, discard_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     entries_q [FifoDepth];
   logic [31:0]     entries_d [FifoDepth];

   logic [FillW-1:0] fill;
   logic             can_start, grant, push, pop, accept;
   logic             unaligned, upper_full, has1, has2, valid_raw, instr_len4;
   logic [CntW-1:0]  wr_idx;
   logic             unused_addr0;

   assign unused_addr0 = addr_i[0];

   // Outstanding counts a request from its first cycle on the bus, granted or not.
   assign fill      = {1'b0, count_q} + FillW'(out_q);
   assign can_start = req_i & ~branch_i & ~req_pend_q &
                      (out_q < OutW'(MaxOutstanding)) & (fill < FillW'(FifoDepth));

   assign instr_req_o  = req_pend_q | can_start;
   assign instr_addr_o = req_pend_q ? req_addr_q : fetch_addr_q;
   assign grant        = instr_req_o & instr_gnt_i;
   assign busy_o       = instr_req_o | (out_q != '0);

   assign push = instr_rvalid_i & ~branch_i & (discard_q == '0);

   assign unaligned  = pc_q[1];
   assign upper_full = entries_q[0][17:16] == 2'b11;
   assign has1       = count_q != '0;
   assign has2       = count_q >= CntW'(2);

   always_comb begin
      valid_raw = has1;
      rdata_o   = entries_q[0];
      if (unaligned) begin
         rdata_o   = {(has2 ? entries_q[1][15:0] : 16'h0000), entries_q[0][31:16]};
         valid_raw = upper_full ? has2 : has1;
      end
   end

   assign valid_o    = valid_raw & ~branch_i;
   assign addr_o     = pc_q;
   assign accept     = valid_o & ready_i;
   assign instr_len4 = rdata_o[1:0] == 2'b11;
   // An aligned compressed instruction leaves its word's upper half in place.
   assign pop        = accept & (unaligned | instr_len4);
   assign wr_idx     = count_q - CntW'(pop);

   always_comb begin
      fetch_addr_d = fetch_addr_q;
      if (branch_i) begin
         fetch_addr_d = {addr_i[31:2], 2'b00};
      end else if (grant & ~(req_pend_q & req_stale_q)) begin
         fetch_addr_d = fetch_addr_q + 32'd4;
      end

      req_pend_d  = instr_req_o & ~instr_gnt_i;
      req_addr_d  = instr_addr_o;
      req_stale_d = req_pend_d & (branch_i | (req_pend_q & req_stale_q));

      out_d = out_q + OutW'(can_start) - OutW'(instr_rvalid_i);

      discard_d = discard_q;
      if (branch_i) begin
         discard_d = out_d;
      end else if (instr_rvalid_i && (discard_q != '0)) begin
         discard_d = discard_q - 2'd1;
      end

      pc_d = pc_q;
      if (branch_i) begin
         pc_d = {addr_i[31:1], 1'b0};
      end else if (accept) begin
         pc_d = pc_q + (instr_len4 ? 32'd4 : 32'd2);
      end
   end

   always_comb begin
      entries_d = entries_q;
      count_d   = count_q;
      if (branch_i) begin
         for (int unsigned i = 0; i < FifoDepth; i++) begin
            entries_d[i] = '0;
         end
         count_d = '0;
      end else begin
         if (pop) begin
            for (int unsigned i = 0; i < FifoDepth - 1; i++) begin
               entries_d[i] = entries_q[i+1];
            end
            entries_d[FifoDepth-1] = '0;
         end
         if (push) begin
            for (int unsigned i = 0; i < FifoDepth; i++) begin
               if (CntW'(i) == wr_idx) begin
                  entries_d[i] = instr_rdata_i;
               end
            end
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_addr_q <= '0;
         req_addr_q   <= '0;
         pc_q         <= '0;
         req_pend_q   <= 1'b0;
         req_stale_q  <= 1'b0;
         out_q        <= '0;
         discard_q    <= '0;
         count_q      <= '0;
         for (int unsigned i = 0; i < FifoDepth; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         fetch_addr_q <= fetch_addr_d;
         req_addr_q   <= req_addr_d;
         pc_q         <= pc_d;
         req_pend_q   <= req_pend_d;
         req_stale_q  <= req_stale_d;
         out_q        <= out_d;
         discard_q    <= discard_d;
         count_q      <= count_d;
         entries_q    <= entries_d;
      end
   end

   // Illegal bus stimulus: a response with nothing outstanding, a grant with no request.
   assert property (@(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> (out_q != '0));
   assert property (@(posedge clk_i) disable iff (!rst_ni) instr_gnt_i |-> instr_req_o);

endmodule

// File: tb/tb_ibex_fetch_fifo.sv
// Directed bench for ibex_fetch_fifo: halfword-stream model checked every cycle
// plus literal expectations for the key fetch scenarios.
module tb_ibex_fetch_fifo;

   localparam int unsigned Depth  = 3;
   localparam int unsigned MaxOut = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, branch, ready;
   logic [31:0] baddr;
   logic        valid;
   logic [31:0] rdata, addr;
   logic        ireq;
   logic [31:0] iaddr;
   logic        gnt, rvalid;
   logic [31:0] irdata;
   logic        busy;
   logic        gnt_hold, rsp_en;

   int checks = 0;
   int errors = 0;

   assign gnt = ireq & ~gnt_hold;

   ibex_fetch_fifo #(
      .FifoDepth      (Depth),
      .MaxOutstanding (MaxOut)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_i          (req),
      .branch_i       (branch),
      .addr_i         (baddr),
      .ready_i        (ready),
      .valid_o        (valid),
      .rdata_o        (rdata),
      .addr_o         (addr),
      .instr_req_o    (ireq),
      .instr_addr_o   (iaddr),
      .instr_gnt_i    (gnt),
      .instr_rvalid_i (rvalid),
      .instr_rdata_i  (irdata),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Memory contents: explicit words per scenario, otherwise a fixed pattern.
   logic [31:0] mem [bit [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[23:8], 16'h0013};
   endfunction

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] ep;
   } gnt_t;

   gnt_t        memq [$];
   logic [15:0] hq [$];
   logic [31:0] pc, next_addr, pend_addr, pend_ep, epoch;
   int          words, inflight;
   bit          pend;
   logic        nxt_rvalid;
   logic [31:0] nxt_rdata;

   task automatic push_word(input logic [31:0] a, input logic [31:0] w);
      if (hq.size() == 0 && pc[1] && a == {pc[31:2], 2'b00}) begin
         hq.push_back(w[31:16]);
      end else begin
         hq.push_back(w[15:0]);
         hq.push_back(w[31:16]);
      end
      words++;
   endtask

   task automatic model_step();
      bit          ev, ereq;
      logic [31:0] erd, cur_a, cur_ep, npc;
      logic [29:0] dw;
      gnt_t        g;
      if (!rst_n) begin
         hq.delete();
         memq.delete();
         pc = '0; next_addr = '0; words = 0; inflight = 0; pend = 0;
         nxt_rvalid = 1'b0; nxt_rdata = '0;
         return;
      end
      ev = !branch && hq.size() >= 1 && (hq[0][1:0] != 2'b11 || hq.size() >= 2);
      chk1("valid_o", valid, ev);
      if (ev) begin
         erd = {(hq.size() >= 2 ? hq[1] : 16'h0000), hq[0]};
         chk("rdata_o", rdata, erd);
      end
      chk("addr_o", addr, pc);
      ereq = pend || (req && !branch && inflight < int'(MaxOut) &&
                      words + inflight < int'(Depth));
      chk1("instr_req_o", ireq, ereq);
      if (ireq) chk("instr_addr_o", iaddr, pend ? pend_addr : next_addr);
      chk1("busy_o", busy, ereq || inflight != 0);

      cur_a  = pend ? pend_addr : next_addr;
      cur_ep = pend ? pend_ep : epoch;
      if (ireq && !pend) inflight++;
      if (rvalid) begin
         if (memq.size() == 0) begin
            chk1("rsp_tracking", 1'b1, 1'b0);
         end else begin
            g = memq.pop_front();
            inflight--;
            if (!branch && g.ep == epoch) push_word(g.a, irdata);
         end
      end
      if (ireq && gnt) begin
         g.a = cur_a;
         g.ep = cur_ep;
         memq.push_back(g);
         if (cur_ep == epoch) next_addr = next_addr + 32'd4;
      end
      pend      = ireq && !gnt;
      pend_addr = cur_a;
      pend_ep   = cur_ep;
      if (ev && ready) begin
         npc = pc + ((hq[0][1:0] == 2'b11) ? 32'd4 : 32'd2);
         if (hq[0][1:0] == 2'b11) void'(hq.pop_front());
         void'(hq.pop_front());
         dw = npc[31:2] - pc[31:2];
         words -= int'(dw);
         pc = npc;
      end
      if (branch) begin
         hq.delete();
         words     = 0;
         pc        = {baddr[31:1], 1'b0};
         next_addr = {baddr[31:2], 2'b00};
         epoch     = epoch + 32'd1;
      end
      nxt_rvalid = rsp_en && memq.size() > 0;
      nxt_rdata  = nxt_rvalid ? mem_rd(memq[0].a) : 32'h0;
   endtask

   always @(negedge clk) model_step();

   initial begin
      rvalid = 1'b0;
      irdata = '0;
      forever begin
         @(posedge clk);
         #1;
         rvalid = nxt_rvalid;
         irdata = nxt_rdata;
      end
   end

   task automatic drive(input bit r, input bit b, input logic [31:0] a, input bit rdy);
      @(posedge clk);
      #1;
      req = r; branch = b; baddr = a; ready = rdy;
   endtask

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         branch = 1'b0;
      end
   endtask

   task automatic drain();
      repeat (4) drive(0, 0, 32'h0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      req = 0; branch = 0; baddr = '0; ready = 0;
      gnt_hold = 0; rsp_en = 1; rst_n = 0; epoch = '0;
      pend_addr = '0; pend_ep = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("reset_valid", valid, 1'b0);
      chk1("reset_req", ireq, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_addr", addr, 32'h0);
      chk("reset_iaddr", iaddr, 32'h0);
      @(posedge clk);
      #1 rst_n = 1;

      // Aligned fetch, then fill until the queue blocks requests.
      mem[32'h100] = 32'h0000_0013;
      drive(1, 1, 32'h100, 0);
      drive(1, 0, 32'h0, 0);
      hold(2);
      @(negedge clk);
      chk1("a_valid", valid, 1'b1);
      chk("a_rdata", rdata, 32'h0000_0013);
      chk("a_addr", addr, 32'h100);
      hold(4);
      @(negedge clk);
      chk1("full_req_blocked", ireq, 1'b0);
      chk1("full_busy", busy, 1'b0);
      drive(1, 0, 32'h0, 1);
      drive(1, 0, 32'h0, 0);
      @(negedge clk);
      chk1("refill_req", ireq, 1'b1);
      chk("refill_iaddr", iaddr, 32'h10C);
      chk("refill_addr", addr, 32'h104);

      // Unaligned compressed instruction.
      drain();
      mem[32'h100] = 32'h4501_0001;
      drive(1, 1, 32'h102, 0);
      drive(1, 0, 32'h0, 0);
      hold(2);
      @(negedge clk);
      chk1("c_valid", valid, 1'b1);
      chk("c_rdata_lo", {16'h0, rdata[15:0]}, 32'h0000_4501);
      chk("c_addr", addr, 32'h102);
      drive(1, 0, 32'h0, 1);
      drive(1, 0, 32'h0, 0);
      @(negedge clk);
      chk("c_next_addr", addr, 32'h104);

      // Unaligned 32-bit instruction spanning two words.
      drain();
      mem[32'h200] = 32'h0093_0000;
      mem[32'h204] = 32'h0000_0513;
      drive(1, 1, 32'h202, 0);
      drive(1, 0, 32'h0, 0);
      hold(2);
      @(negedge clk);
      chk1("s_valid_early", valid, 1'b0);
      hold(1);
      @(negedge clk);
      chk1("s_valid", valid, 1'b1);
      chk("s_rdata", rdata, 32'h0513_0093);
      chk("s_addr", addr, 32'h202);
      drive(1, 0, 32'h0, 1);
      drive(1, 0, 32'h0, 0);
      @(negedge clk);
      chk("s_next_addr", addr, 32'h206);

      // Branch with two responses outstanding: both discarded.
      drain();
      rsp_en = 0;
      drive(1, 1, 32'h300, 0);
      drive(1, 0, 32'h0, 0);
      hold(2);
      @(negedge clk);
      chk1("d_blocked", ireq, 1'b0);
      chk1("d_busy", busy, 1'b1);
      drive(1, 1, 32'h400, 0);
      drive(1, 0, 32'h0, 0);
      rsp_en = 1;
      hold(2);
      @(negedge clk);
      chk1("d_req", ireq, 1'b1);
      chk("d_iaddr", iaddr, 32'h400);
      chk1("d_valid0", valid, 1'b0);
      hold(1);
      @(negedge clk);
      chk1("d_valid1", valid, 1'b0);
      hold(1);
      @(negedge clk);
      chk1("d_valid2", valid, 1'b1);
      chk("d_addr", addr, 32'h400);

      // Branch while a request waits for grant.
      drain();
      gnt_hold = 1;
      drive(1, 1, 32'h500, 0);
      drive(1, 0, 32'h0, 0);
      @(negedge clk);
      chk("g_iaddr0", iaddr, 32'h500);
      drive(1, 1, 32'h600, 0);
      drive(1, 0, 32'h0, 0);
      @(negedge clk);
      chk1("g_req_held", ireq, 1'b1);
      chk("g_iaddr_held", iaddr, 32'h500);
      drive(1, 0, 32'h0, 0);
      gnt_hold = 0;
      drive(1, 0, 32'h0, 0);
      @(negedge clk);
      chk1("g_req_new", ireq, 1'b1);
      chk("g_iaddr_new", iaddr, 32'h600);
      hold(6);

      // Aligned compressed followed by a straddling 32-bit instruction, streaming.
      drain();
      mem[32'h700] = 32'h0513_4501;
      mem[32'h704] = 32'h0000_0093;
      drive(1, 1, 32'h700, 1);
      drive(1, 0, 32'h0, 1);
      hold(12);

      // Address wrap at the top of memory.
      drain();
      drive(1, 1, 32'hFFFF_FFFA, 1);
      drive(1, 0, 32'h0, 1);
      @(negedge clk);
      chk("w_iaddr", iaddr, 32'hFFFF_FFF8);
      hold(10);

      // Reset in the middle of outstanding traffic.
      drain();
      rsp_en = 0;
      drive(1, 1, 32'h800, 0);
      drive(1, 0, 32'h0, 0);
      hold(1);
      @(posedge clk);
      #1;
      req = 0;
      rst_n = 0;
      @(negedge clk);
      chk1("r_valid", valid, 1'b0);
      chk1("r_req", ireq, 1'b0);
      chk1("r_busy", busy, 1'b0);
      chk("r_addr", addr, 32'h0);
      chk("r_iaddr", iaddr, 32'h0);
      chk("r_rdata", rdata, 32'h0);
      hold(1);
      rsp_en = 1;
      hold(1);
      rst_n = 1;
      drive(1, 1, 32'h900, 1);
      drive(1, 0, 32'h0, 1);
      hold(8);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
